// File: rtl/irq_ack_decoder_pkg.sv
// rtl/irq_ack_decoder_pkg.sv - shared types and constants for the acknowledge decoder
package irq_ack_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RELEASE = 2'd2
    } ackState_t;

    localparam logic [7:0] NACK_NONE = 8'hFF;
    localparam int         CNT_W     = 8;

    // Encoder outputs that cannot come from a healthy priority encoder.
    function automatic logic isIllegal(input logic en, input logic [2:0] ny,
                                       input logic nys, input logic nyex);
        return en && ((!nys && !nyex) || (nyex && (ny != 3'b111)));
    endfunction

    // Encoder says "enabled, one request present".
    function automatic logic isValid(input logic en, input logic nys, input logic nyex);
        return en && !nyex && nys;
    endfunction

endpackage

// File: rtl/irq_ack_decoder_if.sv
// rtl/irq_ack_decoder_if.sv - encoder-side inputs and acknowledge-side outputs
interface irq_ack_if;
    logic                           en;
    logic [2:0]                     ny;
    logic                           nys;
    logic                           nyex;
    logic [7:0]                     nack;
    logic [2:0]                     code;
    logic                           busy;
    logic                           err;
    logic [irq_ack_pkg::CNT_W-1:0]  ack_cnt;

    modport master (
        output en, ny, nys, nyex,
        input  nack, code, busy, err, ack_cnt
    );

    modport slave (
        input  en, ny, nys, nyex,
        output nack, code, busy, err, ack_cnt
    );
endinterface

// File: rtl/irq_ack_decoder_dec.sv
// rtl/irq_ack_decoder_dec.sv - 3-to-8 decoder, active-low outputs, active-high enable
module decoder_3to8_n
    import irq_ack_pkg::*;
(
    input  logic       enable,
    input  logic [2:0] sel,
    output logic [7:0] yN
);

    // Pull the selected line low only while enabled; all-ones otherwise.
    always_comb begin
        yN = NACK_NONE;
        if (enable) begin
            yN[sel] = 1'b0;
        end
    end

endmodule

// File: rtl/irq_ack_decoder.sv
// rtl/irq_ack_decoder.sv - latches one encoder request and drives a timed active-low acknowledge
module irq_ack_decoder
    import irq_ack_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    irq_ack_if.slave    bus
);

    ackState_t        state;
    ackState_t        stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [2:0]       codeReg;
    logic [2:0]       codeNext;
    logic             countPending;
    logic             doneNext;
    logic             validReq;
    logic             illegalReq;
    logic             released;
    logic             ackActive;
    logic [7:0]       decoded;

    // Classify the current encoder sample.
    always_comb begin
        validReq   = isValid(bus.en, bus.nys, bus.nyex);
        illegalReq = isIllegal(bus.en, bus.ny, bus.nys, bus.nyex);
        released   = bus.nyex || ((~bus.ny) != codeReg);
        ackActive  = (state == ACK) && bus.en;
    end

    // Next state, hold counter and capture; dropping en aborts from anywhere.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        codeNext  = codeReg;
        doneNext  = 1'b0;
        if (!bus.en) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (validReq) begin
                        codeNext  = ~bus.ny;
                        cntNext   = CNT_W'(HOLD - 1);
                        stateNext = ACK;
                    end
                end
                ACK: begin
                    if (cnt == '0) begin
                        stateNext = RELEASE;
                        doneNext  = 1'b1;
                    end else begin
                        cntNext = cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    if (released) begin
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    decoder_3to8_n u_dec (
        .enable (ackActive),
        .sel    (codeReg),
        .yN     (decoded)
    );

    assign bus.code = codeReg;

    // State and output registers; the count lands one edge after ACK completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            codeReg      <= 3'd0;
            countPending <= 1'b0;
            bus.nack     <= NACK_NONE;
            bus.busy     <= 1'b0;
            bus.err      <= 1'b0;
            bus.ack_cnt  <= '0;
        end else begin
            state        <= stateNext;
            cnt          <= cntNext;
            codeReg      <= codeNext;
            countPending <= doneNext;
            bus.nack     <= decoded;
            bus.busy     <= (state != IDLE) && bus.en;
            bus.err      <= illegalReq;
            if (countPending) begin
                bus.ack_cnt <= bus.ack_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_irq_ack_decoder.sv
// tb/tb_irq_ack_decoder.sv - bench for irq_ack_decoder with HOLD=4 and HOLD=1 instances
module tb_irq_ack_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] ny;
    logic       nys;
    logic       nyex;
    logic       checking = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    irq_ack_if bus4();
    irq_ack_if bus1();

    assign bus4.en = en;  assign bus4.ny = ny;  assign bus4.nys = nys;  assign bus4.nyex = nyex;
    assign bus1.en = en;  assign bus1.ny = ny;  assign bus1.nys = nys;  assign bus1.nyex = nyex;

    irq_ack_decoder #(.HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    irq_ack_decoder #(.HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s hold=%0d: got %0h expected %0h at %0t", name, (k == 0) ? 4 : 1, act, exp, $time);
        end
    endtask

    // Reference: k=0 models HOLD=4, k=1 models HOLD=1.
    int         holdOf[2] = '{4, 1};
    int         mode[2];      // 0 waiting for request, 1 pulsing, 2 waiting for withdrawal
    int         pulsesLeft[2];
    logic [7:0] mNack[2];
    logic [2:0] mCode[2];
    logic       mBusy[2];
    logic       mErr[2];
    logic [7:0] mCnt[2];
    logic       bump[2];

    // Advance the reference one edge using the inputs present at that edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mode[k] = 0; pulsesLeft[k] = 0; mNack[k] = 8'hFF; mCode[k] = 3'd0;
                mBusy[k] = 1'b0; mErr[k] = 1'b0; mCnt[k] = 8'd0; bump[k] = 1'b0;
            end else begin
                mErr[k] = en && ((!nys && !nyex) || (nyex && ny != 3'b111));
                if (bump[k]) mCnt[k] = mCnt[k] + 8'd1;
                bump[k]  = 1'b0;
                mBusy[k] = en && (mode[k] != 0);
                mNack[k] = 8'hFF;
                if (!en) begin
                    mode[k] = 0;
                end else if (mode[k] == 0) begin
                    if (!nyex && nys) begin
                        mCode[k] = ~ny;
                        pulsesLeft[k] = holdOf[k];
                        mode[k] = 1;
                    end
                end else if (mode[k] == 1) begin
                    mNack[k] = ~(8'd1 << mCode[k]);
                    pulsesLeft[k]--;
                    if (pulsesLeft[k] == 0) begin
                        mode[k] = 2;
                        bump[k] = 1'b1;
                    end
                end else begin
                    if (nyex || ((~ny) != mCode[k])) mode[k] = 0;
                end
            end
        end
    end

    // Compare both DUTs against the reference away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                chk("nack",    k, (k == 0) ? bus4.nack    : bus1.nack,    mNack[k]);
                chk("code",    k, (k == 0) ? bus4.code    : bus1.code,    mCode[k]);
                chk("busy",    k, (k == 0) ? bus4.busy    : bus1.busy,    mBusy[k]);
                chk("err",     k, (k == 0) ? bus4.err     : bus1.err,     mErr[k]);
                chk("ack_cnt", k, (k == 0) ? bus4.ack_cnt : bus1.ack_cnt, mCnt[k]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idleInputs();
        en = 1'b1; nys = 1'b0; nyex = 1'b1; ny = 3'b111;
    endtask

    task automatic request(input logic [2:0] idx);
        en = 1'b1; nys = 1'b1; nyex = 1'b0; ny = ~idx;
    endtask

    int lowCnt;
    int matchCnt;
    int low1;

    initial begin
        rst = 1'b1; en = 1'b0; ny = 3'b111; nys = 1'b1; nyex = 1'b1;
        step(2);
        rst = 1'b0;
        checking = 1'b1;
        idleInputs();
        step(3);
        chk("reset_nack", 0, bus4.nack, 8'hFF);
        chk("reset_busy", 0, bus4.busy, 1'b0);
        chk("reset_err",  0, bus4.err, 1'b0);
        chk("reset_cnt",  0, bus4.ack_cnt, 8'd0);

        // Single held request, index 5.
        request(3'd5);
        lowCnt = 0; matchCnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (bus4.nack != 8'hFF) lowCnt++;
            if (bus4.nack == 8'hDF) matchCnt++;
        end
        chk("single_low_cycles", 0, lowCnt, 4);
        chk("single_df_cycles",  0, matchCnt, 4);
        chk("single_code", 0, bus4.code, 3'd5);
        chk("single_busy", 0, bus4.busy, 1'b1);
        chk("single_cnt",  0, bus4.ack_cnt, 8'd1);

        // Priority changes to index 7 while waiting for withdrawal.
        request(3'd7);
        lowCnt = 0; matchCnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (i < 2) chk("prio_gap", 0, bus4.nack, 8'hFF);
            if (bus4.nack != 8'hFF) lowCnt++;
            if (bus4.nack == 8'h7F) matchCnt++;
        end
        chk("prio_low_cycles", 0, lowCnt, 4);
        chk("prio_7f_cycles",  0, matchCnt, 4);
        chk("prio_code", 0, bus4.code, 3'd7);
        chk("prio_cnt",  0, bus4.ack_cnt, 8'd2);
        idleInputs();
        step(3);

        // Abort: en drops during the second ACK cycle.
        request(3'd0);
        step(2);
        chk("abort_first_ack", 0, bus4.nack, 8'hFE);
        en = 1'b0;
        step(1);
        chk("abort_nack", 0, bus4.nack, 8'hFF);
        chk("abort_busy", 0, bus4.busy, 1'b0);
        idleInputs();
        step(3);
        chk("abort_cnt", 0, bus4.ack_cnt, 8'd2);

        // Illegal encoder combinations.
        en = 1'b1; nys = 1'b0; nyex = 1'b0; ny = 3'b111;
        step(1);
        chk("illegal1_err",  0, bus4.err, 1'b1);
        chk("illegal1_nack", 0, bus4.nack, 8'hFF);
        nys = 1'b1; nyex = 1'b1; ny = 3'b101;
        step(1);
        chk("illegal2_err", 0, bus4.err, 1'b1);
        idleInputs();
        step(1);
        chk("illegal_err_clear", 0, bus4.err, 1'b0);
        step(2);
        chk("illegal_no_ack_busy", 0, bus4.busy, 1'b0);
        chk("illegal_no_ack_cnt",  0, bus4.ack_cnt, 8'd2);

        // Reset in the middle of an acknowledge.
        request(3'd3);
        step(2);
        chk("midack_nack", 0, bus4.nack, 8'hF7);
        rst = 1'b1;
        step(1);
        chk("midack_rst_nack", 0, bus4.nack, 8'hFF);
        chk("midack_rst_busy", 0, bus4.busy, 1'b0);
        chk("midack_rst_code", 0, bus4.code, 3'd0);
        chk("midack_rst_cnt",  0, bus4.ack_cnt, 8'd0);
        rst = 1'b0;
        idleInputs();
        step(2);

        // 256 request/withdraw sequences wrap the counter back to zero.
        low1 = 0;
        for (int i = 0; i < 256; i++) begin
            request(3'(i));
            for (int j = 0; j < 6; j++) begin
                step(1);
                if (bus1.nack != 8'hFF) low1++;
            end
            idleInputs();
            for (int j = 0; j < 2; j++) begin
                step(1);
                if (bus1.nack != 8'hFF) low1++;
            end
            if (i == 254) begin
                chk("wrap_255", 0, bus4.ack_cnt, 8'd255);
                chk("wrap_255", 1, bus1.ack_cnt, 8'd255);
            end
        end
        chk("wrap_zero", 0, bus4.ack_cnt, 8'd0);
        chk("wrap_zero", 1, bus1.ack_cnt, 8'd0);
        chk("hold1_low_cycles", 1, low1, 256);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
